// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - ALU word/op types and the ALU request/result interface
package alu_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

interface alu_if;
  import alu_pkg::*;
  word_t  portA;
  word_t  portB;
  aluop_t aluop;
  word_t  portOut;
  logic   negative;
  logic   overflow;
  logic   zero;

  // Request side drives operands/op and samples the combinational result
  modport tb  (output portA, portB, aluop, input portOut, negative, overflow, zero);
  modport alu (input portA, portB, aluop, output portOut, negative, overflow, zero);
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - FIFO-buffered ALU request issuer with in-order response register (option: ALU_SEQ_CHAIN_EN)
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  word_t            req_a,
  input  word_t            req_b,
  input  aluop_t           req_op,
  input  logic [TAG_W-1:0] req_tag,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             req_chain,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output word_t            rsp_out,
  output logic             rsp_neg,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  alu_if.tb                aluif
);
  localparam int AW = $clog2(DEPTH);

  word_t            mem_a   [DEPTH];
  word_t            mem_b   [DEPTH];
  aluop_t           mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop, adv;

  word_t            iss_a, iss_b;
  aluop_t           iss_op;
  logic [TAG_W-1:0] iss_tag;
  logic             iss_valid;
  word_t            port_a;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  // Whole pipeline moves together unless a held response blocks it
  assign adv       = !rsp_valid || rsp_ready;
  assign pop       = adv && !empty;

`ifdef ALU_SEQ_CHAIN_EN
  logic mem_chain [DEPTH];
  logic iss_chain;
  word_t last_result;
  // Chained entries take operand A from the result captured on the edge that issued them
  assign port_a = iss_chain ? last_result : iss_a;
`else
  assign port_a = iss_a;
`endif

  assign aluif.portA = port_a;
  assign aluif.portB = iss_b;
  assign aluif.aluop = iss_op;

  // FIFO storage write; entries need no reset since count gates their use
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a[wr_ptr]   <= req_a;
      mem_b[wr_ptr]   <= req_b;
      mem_op[wr_ptr]  <= req_op;
      mem_tag[wr_ptr] <= req_tag;
`ifdef ALU_SEQ_CHAIN_EN
      mem_chain[wr_ptr] <= req_chain;
`endif
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue stage: registered operands feed the ALU; values hold when it drains
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iss_valid <= 1'b0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_op    <= ALU_SLL;
      iss_tag   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      iss_chain <= 1'b0;
`endif
    end else if (adv) begin
      if (!empty) begin
        iss_valid <= 1'b1;
        iss_a     <= mem_a[rd_ptr];
        iss_b     <= mem_b[rd_ptr];
        iss_op    <= mem_op[rd_ptr];
        iss_tag   <= mem_tag[rd_ptr];
`ifdef ALU_SEQ_CHAIN_EN
        iss_chain <= mem_chain[rd_ptr];
`endif
      end else begin
        iss_valid <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        // Freeze the forwarded operand so portA stays put while idle
        iss_a     <= port_a;
        iss_chain <= 1'b0;
`endif
      end
    end
  end

  // Response register captures the ALU result of the issued entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_neg   <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_tag   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      last_result <= '0;
`endif
    end else if (adv) begin
      rsp_valid <= iss_valid;
      if (iss_valid) begin
        rsp_out  <= aluif.portOut;
        rsp_neg  <= aluif.negative;
        rsp_ovf  <= aluif.overflow;
        rsp_zero <= aluif.zero;
        rsp_tag  <= iss_tag;
`ifdef ALU_SEQ_CHAIN_EN
        last_result <= aluif.portOut;
`endif
      end
    end
  end

  // Sticky overflow: a capture with overflow takes priority over a clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_ovf <= 1'b0;
    end else if (adv && iss_valid && aluif.overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized bench with queue-based reference model for alu_op_sequencer
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  typedef struct packed {
    word_t out;
    logic  neg;
    logic  ovf;
    logic  zero;
  } res_t;

  typedef struct packed {
    res_t             r;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             req_valid, req_ready;
  word_t            req_a, req_b;
  aluop_t           req_op;
  logic [TAG_W-1:0] req_tag;
  logic             chain_drv;
  logic             rsp_valid, rsp_ready;
  word_t            rsp_out;
  logic             rsp_neg, rsp_ovf, rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             sticky_ovf, clr_sticky;

  alu_if aluif();

  always #5 CLK = ~CLK;

  function automatic res_t alu_eval(input word_t a, input word_t b, input aluop_t op);
    res_t  r;
    word_t s;
    r.ovf = 1'b0;
    case (op)
      ALU_SLL:  s = a << b[4:0];
      ALU_SRL:  s = a >> b[4:0];
      ALU_ADD:  begin s = a + b; r.ovf = (a[31] == b[31]) && (s[31] != a[31]); end
      ALU_SUB:  begin s = a - b; r.ovf = (a[31] != b[31]) && (s[31] != a[31]); end
      ALU_AND:  s = a & b;
      ALU_OR:   s = a | b;
      ALU_XOR:  s = a ^ b;
      ALU_NOR:  s = ~(a | b);
      ALU_SLT:  s = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: s = {31'd0, (a < b)};
      default:  s = '0;
    endcase
    r.out  = s;
    r.neg  = s[31];
    r.zero = (s == '0);
    return r;
  endfunction

  // Combinational ALU on the far side of the interface
  res_t alu_r;
  assign alu_r          = alu_eval(aluif.portA, aluif.portB, aluif.aluop);
  assign aluif.portOut  = alu_r.out;
  assign aluif.negative = alu_r.neg;
  assign aluif.overflow = alu_r.ovf;
  assign aluif.zero     = alu_r.zero;

  alu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
`ifdef ALU_SEQ_CHAIN_EN
    .req_chain  (chain_drv),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_neg    (rsp_neg),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero),
    .rsp_tag    (rsp_tag),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky),
    .aluif      (aluif)
  );

  int    n_tests, n_fail, n_rsp;
  exp_t  exp_q[$];
  word_t seen_out[$];
  word_t m_last;
  logic  exp_sticky, prev_valid, prev_hs, prev_clr, last_acc, rnd_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: expected responses in acceptance order, evaluated at the negedge
  task automatic model_check();
    exp_t  e;
    logic  hs, new_rsp, set_s;
    word_t a_eff;
    last_acc = 1'b0;
    if (RST) begin
      exp_q.delete();
      m_last     = '0;
      exp_sticky = 1'b0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_clr   = 1'b0;
      return;
    end
    new_rsp = rsp_valid && (!prev_valid || prev_hs);
    hs      = rsp_valid && rsp_ready;
    set_s   = 1'b0;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_rsp: got rsp_valid=1 tag %0h, no response outstanding at %0t", rsp_tag, $time);
      end else begin
        e = exp_q[0];
        chk("rsp_data", {rsp_out, rsp_neg, rsp_ovf, rsp_zero, rsp_tag}, {e.r, e.tag});
        set_s = new_rsp && e.r.ovf;
      end
    end
    if (set_s) exp_sticky = 1'b1;
    else if (prev_clr) exp_sticky = 1'b0;
    chk("sticky_ovf", sticky_ovf, exp_sticky);
    if (hs && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_rsp++;
      seen_out.push_back(rsp_out);
    end
    if (req_valid && req_ready) begin
      last_acc = 1'b1;
      a_eff    = (chain_drv && CHAIN_ON) ? m_last : req_a;
      e.r      = alu_eval(a_eff, req_b, req_op);
      e.tag    = req_tag;
      m_last   = e.r.out;
      exp_q.push_back(e);
    end
    prev_valid = rsp_valid;
    prev_hs    = hs;
    prev_clr   = clr_sticky;
  endtask

  task automatic tick();
    @(negedge CLK);
    model_check();
    @(posedge CLK);
    #1;
    if (rnd_ready) rsp_ready = $urandom_range(0, 1) == 1;
  endtask

  task automatic send(input word_t a, input word_t b, input aluop_t op,
                      input logic [TAG_W-1:0] tag, input logic ch);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    chain_drv = ch;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept for tag %0h, required accept within 40 cycles", tag);
    end
    req_valid = 1'b0;
    chain_drv = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      tick();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_req(input logic [TAG_W-1:0] tag);
    req_a     = $urandom;
    req_b     = ($urandom_range(0, 3) == 0) ? word_t'($urandom_range(0, 40)) : word_t'($urandom);
    req_op    = aluop_t'(4'($urandom_range(0, 9)));
    req_tag   = tag;
    chain_drv = CHAIN_ON && ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt, rsp0;
    n_tests = 0; n_fail = 0; n_rsp = 0;
    RST = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = ALU_SLL; req_tag = '0;
    chain_drv = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0; rnd_ready = 1'b0;
    m_last = '0; exp_sticky = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; prev_clr = 1'b0; last_acc = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_portA", aluif.portA, 0);
    chk("rst_portB", aluif.portB, 0);
    chk("rst_aluop", aluif.aluop, 0);
    RST = 1'b0;
    tick();

    // ADD overflow: latency of exactly two edges, sticky on the capture edge
    rsp_ready = 1'b1;
    send(32'h7FFF_FFFF, 32'h1, ALU_ADD, 4'd5, 1'b0);
    tick();
    chk("lat_edge1_valid", rsp_valid, 0);
    tick();
    chk("lat_edge2_valid", rsp_valid, 1);
    chk("add_ovf_out", rsp_out, 32'h8000_0000);
    chk("add_ovf_flags", {rsp_neg, rsp_ovf, rsp_zero}, 3'b110);
    chk("add_ovf_sticky", sticky_ovf, 1);
    drain();

    // SUB to zero
    send(32'd5, 32'd5, ALU_SUB, 4'd3, 1'b0);
    repeat (2) tick();
    chk("sub_out", rsp_out, 0);
    chk("sub_flags", {rsp_neg, rsp_ovf, rsp_zero}, 3'b001);
    chk("sub_tag", rsp_tag, 3);
    drain();

    // Fill under backpressure: DEPTH+2 accepted, then in-order release at one per cycle
    rsp_ready = 1'b0;
    nt = 0;
    req_valid = 1'b1;
    rand_req(4'(nt));
    for (int i = 0; i < 15; i++) begin
      tick();
      if (last_acc) begin
        nt++;
        rand_req(4'(nt));
      end
    end
    chk("fill_accepted", nt, DEPTH + 2);
    chk("fill_req_ready", req_ready, 0);
    chk("fill_rsp_held", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
    rsp_ready = 1'b1;
    rsp0 = n_rsp;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) begin
        nt++;
        if (nt == 10) req_valid = 1'b0;
        else rand_req(4'(nt));
      end
    end
    chk("fill_total_accepted", nt, 10);
    chk("fill_rsp_per_cycle", n_rsp - rsp0, 10);
    chk("fill_pipe_empty", rsp_valid, 0);
    req_valid = 1'b0;
    chain_drv = 1'b0;
    drain();

`ifdef ALU_SEQ_CHAIN_EN
    // Chained operations with random backpressure
    seen_out.delete();
    rnd_ready = 1'b1;
    send(32'd1, 32'd2, ALU_ADD, 4'd0, 1'b0);
    send(32'd0, 32'd10, ALU_ADD, 4'd1, 1'b1);
    send(32'd0, 32'd3, ALU_SUB, 4'd2, 1'b1);
    rnd_ready = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("chain_count", seen_out.size(), 3);
    if (seen_out.size() == 3) begin
      chk("chain_r0", seen_out[0], 3);
      chk("chain_r1", seen_out[1], 13);
      chk("chain_r2", seen_out[2], 10);
    end
`endif

    // Asynchronous reset with requests outstanding
    rsp_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h1, ALU_ADD, 4'd1, 1'b0);
    send(32'd1, 32'd1, ALU_ADD, 4'd2, 1'b0);
    send(32'd2, 32'd2, ALU_ADD, 4'd3, 1'b0);
    tick();
    chk("pre_rst_sticky", sticky_ovf, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_req_ready", req_ready, 1);
    chk("async_rst_sticky", sticky_ovf, 0);
    tick();
    RST = 1'b0;
    tick();
    seen_out.delete();
    rsp_ready = 1'b1;
    send(32'd4, 32'd4, ALU_ADD, 4'd7, 1'b0);
    drain();
    chk("post_rst_count", seen_out.size(), 1);
    if (seen_out.size() == 1) chk("post_rst_out", seen_out[0], 8);

    // Clear on the capture edge loses to the set; a later clear wins
    send(32'h7FFF_FFFF, 32'h1, ALU_ADD, 4'd9, 1'b0);
    clr_sticky = 1'b1;
    tick();
    tick();
    chk("clr_same_edge_sticky", sticky_ovf, 1);
    tick();
    chk("clr_next_edge_sticky", sticky_ovf, 0);
    clr_sticky = 1'b0;
    drain();

    // Randomized traffic
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!req_valid || last_acc) begin
        req_valid = $urandom_range(0, 3) != 0;
        rand_req(4'($urandom));
      end
      clr_sticky = $urandom_range(0, 7) == 0;
      tick();
    end
    req_valid  = 1'b0;
    chain_drv  = 1'b0;
    clr_sticky = 1'b0;
    rnd_ready  = 1'b0;
    rsp_ready  = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
